// File: rtl/screen_sequencer_pkg.sv
// Shared types and constants for the full-screen draw controller.
// Holds the screen-mode state encoding and default frame geometry.
package snake_screen_pkg;

    typedef enum logic [3:0] {
        IDLE,
        TITLE,
        TITLE_WAIT,
        FLASH,
        FLASH_WAIT,
        CLEAR,
        PLAY,
        GO,
        GO_HOLD
    } state_e;

    localparam int unsigned H_RES_DEF = 160;
    localparam int unsigned V_RES_DEF = 120;

    localparam logic [2:0] RED   = 3'b100;
    localparam logic [2:0] BLACK = 3'b000;

    function automatic logic is_sweep(input state_e s);
        return (s == TITLE) || (s == FLASH) || (s == CLEAR) || (s == GO);
    endfunction

    function automatic logic is_wait(input state_e s);
        return (s == TITLE_WAIT) || (s == FLASH_WAIT) || (s == GO_HOLD);
    endfunction

endpackage

// File: rtl/screen_sequencer_if.sv
// Bundle of user/game inputs and VGA/ROM-side outputs of the screen sequencer.
// The slave modport is the sequencer side; master is the driver of its inputs.
interface screen_sequencer_if;
    logic        start_btn;
    logic        game_over;
    logic        frame_tick;
    logic [14:0] pix_addr;
    logic [7:0]  x;
    logic [6:0]  y;
    logic        plot;
    logic        show_title;
    logic        show_black;
    logic        show_gameover;
    logic        flash;
    logic        game_en;
    logic        sweep_done;

    modport master (
        output start_btn, game_over, frame_tick,
        input  pix_addr, x, y, plot, show_title, show_black,
               show_gameover, flash, game_en, sweep_done
    );

    modport slave (
        input  start_btn, game_over, frame_tick,
        output pix_addr, x, y, plot, show_title, show_black,
               show_gameover, flash, game_en, sweep_done
    );
endinterface

// File: rtl/screen_sequencer_frame_sweep_counter.sv
// Walks the framebuffer address once per start pulse and emits x/y/plot
// delayed by the image-ROM latency so they line up with the ROM data.
module frame_sweep_counter #(
    parameter int unsigned H_RES   = 160,
    parameter int unsigned V_RES   = 120,
    parameter int unsigned RAM_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [14:0] pix_addr_o,
    output logic [7:0]  x_o,
    output logic [6:0]  y_o,
    output logic        plot_o,
    output logic        done_o
);

    localparam int unsigned PIX = H_RES * V_RES;

    logic        run_q, run_d;
    logic [14:0] addr_q, addr_d;
    logic [7:0]  col_q, col_d;
    logic [6:0]  row_q, row_d;
    logic        issue;
    logic        last_pix;

    logic        vld_q  [RAM_LAT];
    logic        last_q [RAM_LAT];
    logic [7:0]  x_q    [RAM_LAT];
    logic [6:0]  y_q    [RAM_LAT];

    // The start pulse itself issues pixel 0, so the address is live on entry.
    assign issue    = start | run_q;
    assign last_pix = (addr_q == 15'(PIX - 1));

    always_comb begin
        run_d  = run_q;
        addr_d = addr_q;
        col_d  = col_q;
        row_d  = row_q;
        if (issue) begin
            if (last_pix) begin
                run_d  = 1'b0;
                addr_d = '0;
                col_d  = '0;
                row_d  = '0;
            end else begin
                run_d  = 1'b1;
                addr_d = addr_q + 15'd1;
                if (col_q == 8'(H_RES - 1)) begin
                    col_d = '0;
                    row_d = row_q + 7'd1;
                end else begin
                    col_d = col_q + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_q  <= 1'b0;
            addr_q <= '0;
            col_q  <= '0;
            row_q  <= '0;
            for (int i = 0; i < int'(RAM_LAT); i++) begin
                vld_q[i]  <= 1'b0;
                last_q[i] <= 1'b0;
                x_q[i]    <= '0;
                y_q[i]    <= '0;
            end
        end else begin
            run_q     <= run_d;
            addr_q    <= addr_d;
            col_q     <= col_d;
            row_q     <= row_d;
            vld_q[0]  <= issue;
            last_q[0] <= issue & last_pix;
            x_q[0]    <= issue ? col_q : 8'd0;
            y_q[0]    <= issue ? row_q : 7'd0;
            for (int i = 1; i < int'(RAM_LAT); i++) begin
                vld_q[i]  <= vld_q[i-1];
                last_q[i] <= last_q[i-1];
                x_q[i]    <= x_q[i-1];
                y_q[i]    <= y_q[i-1];
            end
        end
    end

    assign pix_addr_o = addr_q;
    assign x_o        = x_q[RAM_LAT-1];
    assign y_o        = y_q[RAM_LAT-1];
    assign plot_o     = vld_q[RAM_LAT-1];
    assign done_o     = last_q[RAM_LAT-1];

endmodule

// File: rtl/screen_sequencer.sv
// Screen-mode controller: picks title/flash/black/game-over fills, runs the
// frame sweep for each, and hands the VGA port to the game renderer in PLAY.
//
// state      | meaning
// IDLE       | one cycle after reset before the first title draw
// TITLE      | sweep drawing the title image
// TITLE_WAIT | title shown, counting frames until the flash redraw
// FLASH      | sweep drawing the title with red pixels blanked
// FLASH_WAIT | flash shown, counting frames until the title redraw
// CLEAR      | black sweep before play
// PLAY       | renderer owns the VGA port
// GO         | red game-over sweep
// GO_HOLD    | game-over locked for HOLD_FRAMES, then waits for start
module screen_sequencer
    import snake_screen_pkg::*;
#(
    parameter int unsigned H_RES        = H_RES_DEF,
    parameter int unsigned V_RES        = V_RES_DEF,
    parameter int unsigned RAM_LAT      = 1,
    parameter int unsigned FLASH_FRAMES = 30,
    parameter int unsigned HOLD_FRAMES  = 120
) (
    input  logic               clk,
    input  logic               rst,
    screen_sequencer_if.slave  bus
);

    state_e     state_q, state_d;
    logic       pending_q, pending_d;
    logic [7:0] cnt_q, cnt_d;
    logic       start_prev_q;
    logic       sweep_start_q;
    logic       show_title_q, show_black_q, show_gameover_q, flash_q, game_en_q;
    logic       start_edge;
    logic       done;

    assign start_edge = bus.start_btn & ~start_prev_q;

    frame_sweep_counter #(
        .H_RES   (H_RES),
        .V_RES   (V_RES),
        .RAM_LAT (RAM_LAT)
    ) u_sweep (
        .clk        (clk),
        .rst        (rst),
        .start      (sweep_start_q),
        .pix_addr_o (bus.pix_addr),
        .x_o        (bus.x),
        .y_o        (bus.y),
        .plot_o     (bus.plot),
        .done_o     (done)
    );

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        cnt_d     = cnt_q;
        unique case (state_q)
            IDLE: state_d = TITLE;
            TITLE, FLASH: begin
                if (start_edge) pending_d = 1'b1;
                if (done) begin
                    if (pending_q || start_edge) state_d = CLEAR;
                    else state_d = (state_q == TITLE) ? TITLE_WAIT : FLASH_WAIT;
                end
            end
            TITLE_WAIT, FLASH_WAIT: begin
                // A start edge wins over a coincident frame_tick.
                if (start_edge || pending_q) begin
                    state_d = CLEAR;
                end else if (bus.frame_tick) begin
                    if (cnt_q == 8'(FLASH_FRAMES - 1))
                        state_d = (state_q == TITLE_WAIT) ? FLASH : TITLE;
                    else
                        cnt_d = cnt_q + 8'd1;
                end
            end
            CLEAR: if (done) state_d = PLAY;
            PLAY:  if (bus.game_over) state_d = GO;
            GO:    if (done) state_d = GO_HOLD;
            GO_HOLD: begin
                if (start_edge && (cnt_q >= 8'(HOLD_FRAMES)))
                    state_d = TITLE;
                else if (bus.frame_tick && (cnt_q < 8'(HOLD_FRAMES)))
                    cnt_d = cnt_q + 8'd1;
            end
            default: state_d = IDLE;
        endcase
        if (state_d == CLEAR) pending_d = 1'b0;
        if (is_wait(state_d) && (state_d != state_q)) cnt_d = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= IDLE;
            pending_q       <= 1'b0;
            cnt_q           <= '0;
            start_prev_q    <= 1'b0;
            sweep_start_q   <= 1'b0;
            show_title_q    <= 1'b0;
            show_black_q    <= 1'b0;
            show_gameover_q <= 1'b0;
            flash_q         <= 1'b0;
            game_en_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            pending_q       <= pending_d;
            cnt_q           <= cnt_d;
            start_prev_q    <= bus.start_btn;
            sweep_start_q   <= is_sweep(state_d) && (state_d != state_q);
            show_title_q    <= (state_d == TITLE);
            show_black_q    <= (state_d == CLEAR);
            show_gameover_q <= (state_d == GO);
            flash_q         <= (state_d == FLASH);
            game_en_q       <= (state_d == PLAY);
        end
    end

    assign bus.show_title    = show_title_q;
    assign bus.show_black    = show_black_q;
    assign bus.show_gameover = show_gameover_q;
    assign bus.flash         = flash_q;
    assign bus.game_en       = game_en_q;
    assign bus.sweep_done    = done;

endmodule

// File: tb/tb_screen_sequencer.sv
// Scoreboard bench for screen_sequencer on a reduced 8x4 frame: each expected
// sweep is queued when triggered and popped as plot pixels come out.
module tb_screen_sequencer;

    localparam int HR = 8;
    localparam int VR = 4;
    localparam int NP = HR * VR;

    localparam logic [3:0] M_TITLE = 4'b1000;
    localparam logic [3:0] M_BLACK = 4'b0100;
    localparam logic [3:0] M_GO    = 4'b0010;
    localparam logic [3:0] M_FLASH = 4'b0001;

    typedef struct packed {
        logic [3:0] mode;
        logic [7:0] x;
        logic [6:0] y;
        logic       last;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_run  = 0;
    int   n_fail = 0;
    exp_t exp_q[$];
    logic prev_plot = 1'b0;
    logic prev_last = 1'b0;

    screen_sequencer_if bus ();

    screen_sequencer #(
        .H_RES        (HR),
        .V_RES        (VR),
        .RAM_LAT      (1),
        .FLASH_FRAMES (2),
        .HOLD_FRAMES  (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] modes();
        return {bus.show_title, bus.show_black, bus.show_gameover, bus.flash};
    endfunction

    task automatic push_sweep(input logic [3:0] mode);
        exp_t e;
        for (int i = 0; i < NP; i++) begin
            e.mode = mode;
            e.x    = 8'(i % HR);
            e.y    = 7'(i / HR);
            e.last = (i == NP - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check_val({tag, "_pix_addr"}, 32'(bus.pix_addr), 0);
        check_val({tag, "_x"},        32'(bus.x), 0);
        check_val({tag, "_y"},        32'(bus.y), 0);
        check_val({tag, "_plot"},     32'(bus.plot), 0);
        check_val({tag, "_modes"},    32'(modes()), 0);
        check_val({tag, "_game_en"},  32'(bus.game_en), 0);
        check_val({tag, "_done"},     32'(bus.sweep_done), 0);
    endtask

    task automatic wait_done(input string tag, input int budget, input int left);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (bus.sweep_done) seen = 1'b1;
        end
        check_val({tag, "_done_seen"}, 32'(seen), 1);
        #1;
        check_val({tag, "_sb_left"}, 32'(exp_q.size()), 32'(left));
    endtask

    task automatic wait_addr(input logic [14:0] target, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (bus.pix_addr == target) seen = 1'b1;
        end
        check_val("addr_reached", 32'(seen), 1);
    endtask

    task automatic tick();
        @(posedge clk); #2 bus.frame_tick = 1'b1;
        @(posedge clk); #2 bus.frame_tick = 1'b0;
    endtask

    // Output monitor: every plotted pixel must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            prev_plot = 1'b0;
            prev_last = 1'b0;
        end else begin
            if (bus.plot) begin
                if (exp_q.size() == 0) begin
                    check_val("unexpected_plot", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check_val("plot_x",    32'(bus.x), 32'(e.x));
                    check_val("plot_y",    32'(bus.y), 32'(e.y));
                    check_val("plot_mode", 32'(modes()), 32'(e.mode));
                    check_val("plot_done", 32'(bus.sweep_done), 32'(e.last));
                end
            end else begin
                if (bus.sweep_done) check_val("done_without_plot", 1, 0);
                if (prev_plot && !prev_last) check_val("plot_gap", 0, 1);
            end
            prev_plot = bus.plot;
            prev_last = bus.sweep_done;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, want finished");
        $fatal(1, "timeout");
    end

    initial begin
        bus.start_btn  = 1'b0;
        bus.game_over  = 1'b0;
        bus.frame_tick = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_idle_outputs("reset");

        // Power-up title sweep
        push_sweep(M_TITLE);
        @(negedge clk) rst = 1'b1;
        @(posedge clk) #1;
        check_val("entry_title", 32'(bus.show_title), 1);
        check_val("entry_plot",  32'(bus.plot), 0);
        check_val("entry_addr",  32'(bus.pix_addr), 0);
        @(posedge clk) #1;
        check_val("plot_latency", 32'(bus.plot), 1);
        check_val("addr_step",    32'(bus.pix_addr), 1);
        wait_done("title0", 64, 0);
        @(posedge clk) #1 check_val("title_wait_modes", 32'(modes()), 0);

        // Title -> flash -> title on frame ticks
        tick();
        check_val("flash_not_yet", 32'(bus.flash), 0);
        push_sweep(M_FLASH);
        tick();
        check_val("flash_entry", 32'(bus.flash), 1);
        wait_done("flash", 64, 0);
        tick();
        push_sweep(M_TITLE);
        tick();
        check_val("title_again", 32'(bus.show_title), 1);

        // Start mid-sweep is latched; sweep finishes, then black
        wait_addr(15'd10, 64);
        bus.start_btn = 1'b1;
        push_sweep(M_BLACK);
        wait_done("title_pend", 64, NP);
        @(posedge clk) #1 check_val("clear_entry", 32'(modes()), 32'(M_BLACK));
        wait_done("clear", 64, 0);
        @(posedge clk) #1;
        check_val("play_game_en", 32'(bus.game_en), 1);
        check_val("play_plot",    32'(bus.plot), 0);
        check_val("play_modes",   32'(modes()), 0);

        // start ignored in PLAY
        bus.start_btn = 1'b0;
        repeat (2) @(posedge clk);
        #2 bus.start_btn = 1'b1;
        repeat (4) @(posedge clk);
        #1 check_val("play_ignores_start", 32'(bus.game_en), 1);
        bus.start_btn = 1'b0;

        // Game over and hold lockout
        @(posedge clk) #2 bus.game_over = 1'b1;
        push_sweep(M_GO);
        @(posedge clk) #2 bus.game_over = 1'b0;
        check_val("go_entry", 32'(bus.show_gameover), 1);
        wait_done("go", 64, 0);
        @(posedge clk) #1 check_val("hold_modes", 32'(modes()), 0);
        tick();
        @(posedge clk) #2 bus.start_btn = 1'b1;
        repeat (4) @(posedge clk);
        #1 check_val("hold_lock", 32'(bus.show_title), 0);
        bus.start_btn = 1'b0;
        tick();
        tick();
        @(posedge clk) #2 bus.start_btn = 1'b1;
        push_sweep(M_TITLE);
        @(posedge clk) #1 check_val("hold_release", 32'(bus.show_title), 1);
        wait_done("title_after_go", 64, 0);
        repeat (6) @(posedge clk);
        #1 check_val("held_start_one_edge", 32'(bus.show_black), 0);
        bus.start_btn = 1'b0;

        // Start and frame_tick coincide on the would-be flash tick
        tick();
        @(posedge clk) #2;
        bus.frame_tick = 1'b1;
        bus.start_btn  = 1'b1;
        push_sweep(M_BLACK);
        @(posedge clk) #1;
        check_val("coincide_black", 32'(bus.show_black), 1);
        check_val("coincide_flash", 32'(bus.flash), 0);
        #1 bus.frame_tick = 1'b0;

        // Asynchronous reset mid black sweep
        wait_addr(15'd17, 64);
        #1 rst = 1'b0;
        #1 check_idle_outputs("async_rst");
        exp_q.delete();
        bus.start_btn = 1'b0;
        repeat (2) @(posedge clk);
        push_sweep(M_TITLE);
        @(negedge clk) rst = 1'b1;
        @(posedge clk) #1 check_val("restart_title", 32'(bus.show_title), 1);
        wait_done("title_restart", 64, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
